// File: rtl/mips_cpu_load_pkg.sv
// Shared definitions for the MIPS load unit: opcodes, FSM states, error codes.
// No logic beyond a small misalignment helper used by the optional align check.
// Optional feature macro: MIPS_LOAD_ALIGN_CHECK_EN (see mips_cpu_load_unit).
package mips_cpu_load_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LWL = 6'b100010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LWR = 6'b100110;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
   localparam logic [1:0] ERR_MISALIGN = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } load_state_t;

   // Halfword loads need an even address, LW needs a word-aligned address.
   function automatic logic is_misaligned(input logic [5:0] opcode, input logic [1:0] offset);
      return (((opcode == OP_LH) || (opcode == OP_LHU)) && offset[0]) ||
             ((opcode == OP_LW) && (offset != 2'b00));
   endfunction

endpackage

// File: rtl/mips_cpu_load_merge.sv
// Byte-lane extraction, sign/zero extension and LWL/LWR merge of one read word.
// Latency: purely combinational.
// Backpressure: none; the caller samples the result when the read data is valid.
module mips_cpu_load_merge
   import mips_cpu_load_pkg::*;
#(
   parameter int MEM_LE_LANES = 1
) (
   input  logic [5:0]  opcode,
   input  logic [1:0]  offset,
   input  logic [31:0] readdata,
   input  logic [31:0] rt_data,
   output logic [31:0] merged
);

   // w holds {b0,b1,b2,b3}: byte at address offset 0 in the top lane.
   logic [31:0] w;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign w = (MEM_LE_LANES != 0) ?
              {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]} : readdata;

   // Select the addressed byte/halfword, then build the writeback word per opcode.
   always_comb begin
      merged   = w;
      byte_sel = w[31:24];
      case (offset)
         2'd0:    byte_sel = w[31:24];
         2'd1:    byte_sel = w[23:16];
         2'd2:    byte_sel = w[15:8];
         default: byte_sel = w[7:0];
      endcase
      half_sel = offset[1] ? w[15:0] : w[31:16];
      case (opcode)
         OP_LB:   merged = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  merged = {24'd0, byte_sel};
         OP_LH:   merged = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  merged = {16'd0, half_sel};
         OP_LWL: begin
            case (offset)
               2'd0:    merged = w;
               2'd1:    merged = {w[23:0], rt_data[7:0]};
               2'd2:    merged = {w[15:0], rt_data[15:0]};
               default: merged = {w[7:0], rt_data[23:0]};
            endcase
         end
         OP_LWR: begin
            case (offset)
               2'd0:    merged = {rt_data[31:8], w[31:24]};
               2'd1:    merged = {rt_data[31:16], w[31:16]};
               2'd2:    merged = {rt_data[31:24], w[31:8]};
               default: merged = w;
            endcase
         end
         default: merged = w;
      endcase
   end

endmodule

// File: rtl/mips_cpu_load_unit.sv
// Multi-cycle load unit: accepts one load, issues one aligned read, returns the writeback value.
// Latency: accept edge T, mem_read in the cycle after T, out_valid from edge T+2 (+ wait cycles).
// Backpressure: mem_waitrequest stalls REQ (aborts after TIMEOUT_CYCLES); result held until out_ready.
// Optional: define MIPS_LOAD_ALIGN_CHECK_EN to reject misaligned LH/LHU/LW with out_err=2.
module mips_cpu_load_unit
   import mips_cpu_load_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int MEM_LE_LANES   = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [31:0]       in_rt_data,
   input  logic [4:0]        in_rt_idx,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_address,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic [4:0]        out_rt_idx,
   output logic [1:0]        out_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   load_state_t   state;
   logic [5:0]    op_q;
   logic [1:0]    off_q;
   logic [31:0]   rt_q;
   logic [TW-1:0] tcount;
   logic [31:0]   merged;
   logic          accept;
   logic          misalign;

   assign in_ready = (state == IDLE) || ((state == RESP) && out_ready);
   assign accept   = in_valid && in_ready;

`ifdef MIPS_LOAD_ALIGN_CHECK_EN
   assign misalign = is_misaligned(in_opcode, in_address[1:0]);
`else
   assign misalign = 1'b0;
`endif

   mips_cpu_load_merge #(
      .MEM_LE_LANES (MEM_LE_LANES)
   ) u_merge (
      .opcode   (op_q),
      .offset   (off_q),
      .readdata (mem_readdata),
      .rt_data  (rt_q),
      .merged   (merged)
   );

   // FSM: inside REQ, mem_read high means the read is still outstanding; once the word
   // is captured mem_read drops and the following edge presents the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         off_q       <= '0;
         rt_q        <= '0;
         tcount      <= '0;
         mem_read    <= 1'b0;
         mem_address <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_rt_idx  <= '0;
         out_err     <= ERR_NONE;
      end else begin
         case (state)
            REQ: begin
               if (mem_read) begin
                  if (!mem_waitrequest) begin
                     out_data <= merged;
                     mem_read <= 1'b0;
                  end else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
                     mem_read  <= 1'b0;
                     state     <= RESP;
                     out_valid <= 1'b1;
                     out_data  <= rt_q;
                     out_err   <= ERR_TIMEOUT;
                  end else begin
                     tcount <= tcount + 1'b1;
                  end
               end else begin
                  state     <= RESP;
                  out_valid <= 1'b1;
               end
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: ;
         endcase

         // A new accept (from IDLE or back-to-back from RESP) overrides the above.
         if (accept) begin
            op_q       <= in_opcode;
            off_q      <= in_address[1:0];
            rt_q       <= in_rt_data;
            out_rt_idx <= in_rt_idx;
            out_err    <= ERR_NONE;
            if (misalign) begin
               state     <= RESP;
               out_valid <= 1'b1;
               out_data  <= in_rt_data;
               out_err   <= ERR_MISALIGN;
            end else begin
               state       <= REQ;
               mem_read    <= 1'b1;
               mem_address <= {in_address[ADDR_W-1:2], 2'b00};
               tcount      <= '0;
               out_valid   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Self-checking bench for mips_cpu_load_unit: directed scenarios plus a randomised loop.
// Expected results are queued at accept and compared when the result handshake completes.
// Honours MIPS_LOAD_ALIGN_CHECK_EN in the same way as the design.
module tb_mips_cpu_load_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_opcode = '0;
   logic [31:0] in_address = '0;
   logic [31:0] in_rt_data = '0;
   logic [4:0]  in_rt_idx = '0;
   logic        mem_read;
   logic [31:0] mem_address;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_rt_idx;
   logic [1:0]  out_err;

   int total = 0;
   int bad = 0;

   int          wait_cfg = 0;
   int          wcnt = 0;
   logic [31:0] rd_word = '0;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  err;
      logic [4:0]  idx;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   // Memory responder: waitrequest for wait_cfg cycles of each read, then data.
   assign mem_waitrequest = mem_read && (wcnt < wait_cfg);
   assign mem_readdata    = rd_word;
   always @(posedge clk) wcnt <= (mem_read && mem_waitrequest) ? wcnt + 1 : 0;

   mips_cpu_load_unit dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_opcode       (in_opcode),
      .in_address      (in_address),
      .in_rt_data      (in_rt_data),
      .in_rt_idx       (in_rt_idx),
      .mem_read        (mem_read),
      .mem_address     (mem_address),
      .mem_waitrequest (mem_waitrequest),
      .mem_readdata    (mem_readdata),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_rt_idx      (out_rt_idx),
      .out_err         (out_err)
   );

   // Reference: bytes indexed by address offset, assembled by explicit loops.
   function automatic logic [31:0] model_data(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] rd, input logic [31:0] rt);
      logic [7:0]  b [4];
      logic [31:0] r;
      int o, h;
      for (int k = 0; k < 4; k++) b[k] = rd[8*k +: 8];
      o = int'(a);
      h = int'(a[1]);
      r = '0;
`ifdef MIPS_LOAD_ALIGN_CHECK_EN
      if (((op == 6'h21 || op == 6'h25) && a[0]) || (op == 6'h23 && a != 2'b00)) return rt;
`endif
      case (op)
         6'h20: r = {{24{b[o][7]}}, b[o]};
         6'h24: r = {24'd0, b[o]};
         6'h21: r = {{16{b[2*h][7]}}, b[2*h], b[2*h+1]};
         6'h25: r = {16'd0, b[2*h], b[2*h+1]};
         6'h22: begin
            r = rt;
            for (int k = o; k < 4; k++) r[31-8*(k-o) -: 8] = b[k];
         end
         6'h26: begin
            r = rt;
            for (int k = 0; k <= o; k++) r[8*(o-k) +: 8] = b[k];
         end
         default: r = {b[0], b[1], b[2], b[3]};
      endcase
      return r;
   endfunction

   function automatic logic [1:0] model_err(input logic [5:0] op, input logic [1:0] a);
`ifdef MIPS_LOAD_ALIGN_CHECK_EN
      if (((op == 6'h21 || op == 6'h25) && a[0]) || (op == 6'h23 && a != 2'b00)) return 2'd2;
`endif
      return 2'd0;
   endfunction

   // Scoreboard: a result handshake seen at negedge completes on the next posedge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         exp_t e;
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got data=%h err=%0d idx=%0d, expected no result",
                     out_data, out_err, out_rt_idx);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.data || out_err !== e.err || out_rt_idx !== e.idx) begin
               bad++;
               $display("FAIL sb_result: got data=%h err=%0d idx=%0d, expected data=%h err=%0d idx=%0d",
                        out_data, out_err, out_rt_idx, e.data, e.err, e.idx);
            end
         end
      end
   end

   // Present an op, wait (bounded) for in_ready, queue its expectation; returns #1 after accept edge.
   task automatic drive_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [4:0] idx, input logic [31:0] ed, input logic [1:0] ee);
      bit ok = 0;
      in_opcode = op; in_address = addr; in_rt_data = rt; in_rt_idx = idx; in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (in_ready) begin
            sb.push_back('{ed, ee, idx});
            ok = 1;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready); end
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
         if (out_valid) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL valid_timeout: out_valid=%b, required 1", out_valid); end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({in_ready, mem_read, out_valid, out_data, out_rt_idx, out_err, mem_address} !== {1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 2'd0, 32'd0}) begin
         bad++;
         $display("FAIL reset_state: rdy=%b rd=%b vld=%b data=%h idx=%0d err=%0d addr=%h, required 1 0 0 0 0 0 0",
                  in_ready, mem_read, out_valid, out_data, out_rt_idx, out_err, mem_address);
      end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_lb_latency();
      out_ready = 1'b0; wait_cfg = 0; rd_word = 32'h8000_0000;
      drive_op(6'h20, 32'h1003, 32'h0, 5'd5, 32'hFFFF_FF80, 2'd0);
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h1000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL lb_t1: rd=%b addr=%h vld=%b, required 1 00001000 0", mem_read, mem_address, out_valid);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL lb_t2_early: out_valid=%b, required 0", out_valid); end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FF80 || out_err !== 2'd0 || out_rt_idx !== 5'd5) begin
         bad++;
         $display("FAIL lb_t2: vld=%b data=%h err=%0d idx=%0d, required 1 ffffff80 0 5",
                  out_valid, out_data, out_err, out_rt_idx);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL lb_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_lwl_lwr();
      out_ready = 1'b1; wait_cfg = 0; rd_word = 32'h4433_2211;
      drive_op(6'h22, 32'h2001, 32'hAABB_CCDD, 5'd7, 32'h2233_44DD, 2'd0);
      wait_valid();
      total++;
      if (out_data !== 32'h2233_44DD) begin bad++; $display("FAIL lwl: out_data=%h, required 223344dd", out_data); end
      @(posedge clk); #1;
      drive_op(6'h26, 32'h2001, 32'hAABB_CCDD, 5'd8, 32'hAABB_1122, 2'd0);
      wait_valid();
      total++;
      if (out_data !== 32'hAABB_1122) begin bad++; $display("FAIL lwr: out_data=%h, required aabb1122", out_data); end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_wait_lw();
      int n = 0;
      bit addr_ok = 1;
      out_ready = 1'b0; wait_cfg = 5; rd_word = 32'h0403_0201;
      drive_op(6'h23, 32'h2000, 32'h0, 5'd3, 32'h0102_0304, 2'd0);
      for (int i = 0; i < 40; i++) begin
         if (!mem_read) break;
         n++;
         if (mem_address !== 32'h2000) addr_ok = 0;
         @(posedge clk); #1;
      end
      total++;
      if (n != 6 || !addr_ok) begin
         bad++;
         $display("FAIL wait_hold: read cycles=%0d addr_stable=%0d, required 6 1", n, addr_ok);
      end
      wait_valid();
      total++;
      if (out_data !== 32'h0102_0304) begin bad++; $display("FAIL wait_lw: out_data=%h, required 01020304", out_data); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; wait_cfg = 0;
   endtask

   task automatic test_timeout();
      int n = 0;
      out_ready = 1'b0; wait_cfg = 1000;
      drive_op(6'h23, 32'h2004, 32'h1234_5678, 5'd9, 32'h1234_5678, 2'd1);
      for (int i = 0; i < 60; i++) begin
         if (!mem_read) break;
         n++;
         @(posedge clk); #1;
      end
      total++;
      if (n != 16) begin bad++; $display("FAIL timeout_len: read cycles=%0d, required 16", n); end
      total++;
      if (out_valid !== 1'b1 || out_err !== 2'd1 || out_data !== 32'h1234_5678) begin
         bad++;
         $display("FAIL timeout_result: vld=%b err=%0d data=%h, required 1 1 12345678", out_valid, out_err, out_data);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; wait_cfg = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ea, eb;
      bit stable = 1;
      out_ready = 1'b0; wait_cfg = 0; rd_word = 32'hCAFE_F00D;
      ea = model_data(6'h23, 2'd0, rd_word, 32'h0);
      eb = model_data(6'h20, 2'd1, rd_word, 32'h0);
      drive_op(6'h23, 32'h100, 32'h0, 5'd1, ea, 2'd0);
      wait_valid();
      in_opcode = 6'h20; in_address = 32'h201; in_rt_data = 32'h0; in_rt_idx = 5'd2; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ea) stable = 0;
         @(posedge clk); #1;
      end
      total++;
      if (!stable) begin bad++; $display("FAIL b2b_hold: rdy=%b vld=%b data=%h, required 0 1 %h", in_ready, out_valid, out_data, ea); end
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready); end
      sb.push_back('{eb, 2'd0, 5'd2});
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 32'h200) begin
         bad++;
         $display("FAIL b2b_nobubble: vld=%b rd=%b addr=%h, required 0 1 00000200", out_valid, mem_read, mem_address);
      end
      wait_valid();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_misalign();
      bit saw_read = 0;
      out_ready = 1'b0; wait_cfg = 0; rd_word = 32'h1122_3344;
      drive_op(6'h23, 32'h3002, 32'h5A5A_5A5A, 5'd11,
               model_data(6'h23, 2'd2, rd_word, 32'h5A5A_5A5A), model_err(6'h23, 2'd2));
      for (int i = 0; i < 20; i++) begin
         if (mem_read) begin
            saw_read = 1;
            total++;
            if (mem_address !== 32'h3000) begin bad++; $display("FAIL mis_addr: mem_address=%h, required 00003000", mem_address); end
         end
         if (out_valid) break;
         @(posedge clk); #1;
      end
`ifdef MIPS_LOAD_ALIGN_CHECK_EN
      total++;
      if (saw_read || out_valid !== 1'b1 || out_err !== 2'd2 || out_data !== 32'h5A5A_5A5A) begin
         bad++;
         $display("FAIL misalign: read=%0d vld=%b err=%0d data=%h, required 0 1 2 5a5a5a5a", saw_read, out_valid, out_err, out_data);
      end
`else
      total++;
      if (!saw_read || out_valid !== 1'b1 || out_err !== 2'd0 || out_data !== 32'h4433_2211) begin
         bad++;
         $display("FAIL misalign_off: read=%0d vld=%b err=%0d data=%h, required 1 1 0 44332211", saw_read, out_valid, out_err, out_data);
      end
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      ops = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h00};
      for (int n = 0; n < 40; n++) begin
         logic [5:0]  op;
         logic [31:0] addr, rt;
         logic [4:0]  idx;
         op = ops[$urandom_range(0, 7)];
         addr = $urandom; rt = $urandom; idx = 5'($urandom_range(0, 31));
         rd_word = $urandom; wait_cfg = $urandom_range(0, 3);
         drive_op(op, addr, rt, idx, model_data(op, addr[1:0], rd_word, rt), model_err(op, addr[1:0]));
         for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         out_ready = 1'b0;
         total++;
         if (sb.size() != 0) begin bad++; $display("FAIL rand_drain: pending=%0d, required 0", sb.size()); sb.delete(); end
      end
      wait_cfg = 0;
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; wait_cfg = 1000;
      drive_op(6'h23, 32'h4000, 32'h0, 5'd4, 32'h0, 2'd0);
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (mem_read !== 1'b1) begin bad++; $display("FAIL rmid_pre: mem_read=%b, required 1", mem_read); end
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (mem_read !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid: rd=%b vld=%b, required 0 0", mem_read, out_valid);
      end
      sb.delete();
      reset = 1'b0; wait_cfg = 0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rmid_after: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_lb_latency();
      test_lwl_lwr();
      test_wait_lw();
      test_timeout();
      test_back_to_back();
      test_misalign();
      test_random();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: pending=%0d, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
